sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the CPU's SRAM strobe interface: Mem_CE, Mem_OE, Mem_WE, Mem_UB and Mem_LB, all active-low, plus address and write data.
- Holds an on-chip 16-bit word array and answers reads and writes with a programmable number of wait states.
- Serves as the synthesizable stand-in for the board SRAM in simulation and on-chip builds, and sits directly below the CPU's MAR/MDR datapath.

Parameters:
- ADDR_W, 10, address width in bits; DEPTH = 2**ADDR_W words.
- WAIT_CYCLES, 0, extra clocks between the request sample edge and the data/commit phase (0..15).

Ports:
- Clk  in  1  system clock; everything rises on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Mem_CE  in  1  chip enable, active-low.
- Mem_OE  in  1  output enable (read request), active-low.
- Mem_WE  in  1  write enable (write request), active-low.
- Mem_UB  in  1  upper byte lane enable [15:8], active-low.
- Mem_LB  in  1  lower byte lane enable [7:0], active-low.
- ADDR  in  ADDR_W  word address.
- Data_to_SRAM  in  16  write data.
- Data_from_SRAM  out  16  registered read data.
- Rdy  out  1  high while read data is valid or a write has committed.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Data_from_SRAM=16'h0000; Rdy=0; wait counter 0. The array is not reset.
- Request decode, sampled at posedge in IDLE only:
  - Write request = CE=0 and WE=0. WE wins when OE and WE are both low.
  - Read request = CE=0, OE=0, WE=1.
  - CE=1 ignores all strobes.
- Capture: ADDR, Data_to_SRAM, UB and LB are latched at the sample edge. Later changes on these inputs are ignored until the next IDLE.
- States: IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE.
- IDLE transitions:
  - Read request -> RD_DATA if WAIT_CYCLES=0, else RD_WAIT with cnt=WAIT_CYCLES-1.
  - Write request -> WR_DONE if WAIT_CYCLES=0, committing at that same edge; else WR_WAIT with cnt=WAIT_CYCLES-1.
- RD_WAIT: each edge, if OE=1 or CE=1 go to IDLE (abort, no data). Else if cnt=0 go to RD_DATA, else cnt--.
- Entering RD_DATA:
  - Data_from_SRAM loads mem[addr]; lanes whose latched enable is 1 read as 8'h00.
  - Rdy=1.
- RD_DATA: held stable while CE=0 and OE=0. On the edge sampling OE=1 or CE=1, go to IDLE; Rdy=0; Data_from_SRAM holds its last value.
- Read latency: with WAIT_CYCLES=0, OE is low in cycle n and data is valid during cycle n+1. This matches a two-cycle OE window that loads MDR at the end of the second cycle. In general, data is valid WAIT_CYCLES+1 cycles after the first OE-low cycle.
- WR_WAIT: each edge, if WE=1 or CE=1 go to IDLE (abort, array unchanged). Else if cnt=0, commit and go to WR_DONE; else cnt--.
- Commit: mem[addr][15:8] is written if the latched UB=0; mem[addr][7:0] is written if the latched LB=0. UB=LB=1 commits nothing but still completes the handshake.
- WR_DONE: Rdy=1. Exactly one commit per request, even if WE stays low. Go to IDLE on the edge sampling WE=1 or CE=1.
- Back-to-back: a new request needs one IDLE sample, so strobes must deassert for at least one edge between accesses.
- Address is used modulo DEPTH; no wrap error.
- Reset mid-operation aborts any pending write; the array keeps prior contents.

Optional Feature:
- Macro SRAM_RESPONDER_STATS_EN.
- When defined, adds two ports:
  - Rd_Count  out  16  increments on each entry to RD_DATA.
  - Wr_Count  out  16  increments on each commit.
- Both counters reset to 0 and wrap from 16'hFFFF to 16'h0000. Aborted requests are not counted.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset low mid-RD_WAIT (WAIT_CYCLES=3) -> Rdy=0 and Data_from_SRAM=0 immediately (asynchronous); after release, IDLE accepts a new request on the next edge.
- WAIT_CYCLES=0: write 16'h1234 to addr 5 (WE low 2 cycles, UB=LB=0), then read addr 5 with OE low 2 cycles -> Data_from_SRAM=16'h1234 in the second OE cycle, Rdy=1.
- Byte lanes: write 16'hABCD to addr 7 with UB=1, LB=0, over prior 16'h1111 -> read returns 16'h11CD; read with LB=1 returns 16'h1100.
- WAIT_CYCLES=3: OE low at cycle n -> Rdy rises at cycle n+4; OE raised at n+2 -> no Rdy, returns to IDLE.
- WE held low 10 cycles at addr 9 while Data_to_SRAM changes each cycle -> only the value present at the sample edge is stored; exactly one commit.
- OE and WE both low, CE=0 -> treated as a write. CE=1 with OE=0 -> no response and Rdy stays 0. With SRAM_RESPONDER_STATS_EN, after 3 reads and 2 writes -> Rd_Count=3, Wr_Count=2.

Source files
------------

// File: rtl/sram_responder.sv
// On-chip 16-bit SRAM stand-in answering the CPU's active-low strobe interface
// with WAIT_CYCLES wait states. Define SRAM_RESPONDER_STATS_EN to add Rd_Count/Wr_Count.
module sram_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_CE,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic              Mem_UB,
   input  logic              Mem_LB,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [15:0]       Data_to_SRAM,
   output logic [15:0]       Data_from_SRAM,
   output logic              Rdy
`ifdef SRAM_RESPONDER_STATS_EN
   ,
   output logic [15:0]       Rd_Count,
   output logic [15:0]       Wr_Count
`endif
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE} state_t;

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] addr_q, acc_addr;
   logic [15:0]       wdata_q, acc_wdata, rd_word;
   logic              ub_q, lb_q, acc_ub, acc_lb;
   logic              commit, load;
   logic              wr_req, rd_req;
   logic [15:0]       mem [DEPTH];

   assign wr_req = !Mem_CE && !Mem_WE;
   assign rd_req = !Mem_CE && !Mem_OE && Mem_WE;

   // In IDLE the zero-wait path acts on the live inputs, otherwise on the latched request.
   always_comb begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_ub    = ub_q;
      acc_lb    = lb_q;
      if (state == IDLE) begin
         acc_addr  = ADDR;
         acc_wdata = Data_to_SRAM;
         acc_ub    = Mem_UB;
         acc_lb    = Mem_LB;
      end
   end

   always_comb begin
      rd_word = mem[acc_addr];
      if (acc_ub) rd_word[15:8] = 8'h00;
      if (acc_lb) rd_word[7:0]  = 8'h00;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (wr_req) begin
               if (WAIT_CYCLES == 0) begin
                  state_n = WR_DONE;
                  commit  = 1'b1;
               end else begin
                  state_n = WR_WAIT;
                  cnt_n   = CNT_INIT;
               end
            end else if (rd_req) begin
               if (WAIT_CYCLES == 0) begin
                  state_n = RD_DATA;
                  load    = 1'b1;
               end else begin
                  state_n = RD_WAIT;
                  cnt_n   = CNT_INIT;
               end
            end
         end
         RD_WAIT: begin
            if (Mem_OE || Mem_CE) state_n = IDLE;
            else if (cnt == 4'd0) begin
               state_n = RD_DATA;
               load    = 1'b1;
            end else cnt_n = cnt - 4'd1;
         end
         RD_DATA: if (Mem_OE || Mem_CE) state_n = IDLE;
         WR_WAIT: begin
            if (Mem_WE || Mem_CE) state_n = IDLE;
            else if (cnt == 4'd0) begin
               state_n = WR_DONE;
               commit  = 1'b1;
            end else cnt_n = cnt - 4'd1;
         end
         WR_DONE: if (Mem_WE || Mem_CE) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         Rdy            <= 1'b0;
         Data_from_SRAM <= 16'h0000;
         addr_q         <= '0;
         wdata_q        <= 16'h0000;
         ub_q           <= 1'b1;
         lb_q           <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         Rdy   <= (state_n == RD_DATA) || (state_n == WR_DONE);
         if (load) Data_from_SRAM <= rd_word;
         if (state == IDLE) begin
            addr_q  <= ADDR;
            wdata_q <= Data_to_SRAM;
            ub_q    <= Mem_UB;
            lb_q    <= Mem_LB;
         end
      end
   end

   // Array is never reset; Reset gates the write so a held-in-reset bus cannot commit.
   always_ff @(posedge Clk) begin
      if (commit && Reset) begin
         if (!acc_ub) mem[acc_addr][15:8] <= acc_wdata[15:8];
         if (!acc_lb) mem[acc_addr][7:0]  <= acc_wdata[7:0];
      end
   end

`ifdef SRAM_RESPONDER_STATS_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Rd_Count <= 16'h0000;
         Wr_Count <= 16'h0000;
      end else begin
         if (load)   Rd_Count <= Rd_Count + 16'd1;
         if (commit) Wr_Count <= Wr_Count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench: drives two responders (0 and 3 wait states) from one bus and
// checks them against a transaction-level model of the access rules.
module tb_sram_responder;
   localparam int AW  = 10;
   localparam int W_A = 0;
   localparam int W_B = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
   logic [AW-1:0] ADDR;
   logic [15:0]   Data_to_SRAM;
   logic [15:0]   dout0, dout1;
   logic          rdy0, rdy1;
`ifdef SRAM_RESPONDER_STATS_EN
   logic [15:0]   rdc0, rdc1, wrc0, wrc1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mmem [2][1024];
   logic [15:0] last [2];
   int          rdn  [2];
   int          wrn  [2];

   sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W_A)) u_w0 (
      .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
      .Data_from_SRAM(dout0), .Rdy(rdy0)
`ifdef SRAM_RESPONDER_STATS_EN
      , .Rd_Count(rdc0), .Wr_Count(wrc0)
`endif
   );

   sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W_B)) u_w3 (
      .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
      .Data_from_SRAM(dout1), .Rdy(rdy1)
`ifdef SRAM_RESPONDER_STATS_EN
      , .Rd_Count(rdc1), .Wr_Count(wrc1)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] masked(input logic [15:0] w, input bit ub, input bit lb);
      return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
   endfunction

   // One access: strobes low for len cycles, then one deasserted cycle.
   // It completes only if the strobes stay low for wait+1 sample edges.
   task automatic xfer(input bit wr, input bit both, input bit ce_off, input int len,
                       input logic [AW-1:0] a, input logic [15:0] wd, input bit ub, input bit lb);
      bit          done [2];
      logic [15:0] nd   [2];
      int          w;
      for (int d = 0; d < 2; d++) begin
         w       = (d == 0) ? W_A : W_B;
         done[d] = !ce_off && (len >= w + 1);
         nd[d]   = masked(mmem[d][a], ub, lb);
      end
      for (int k = 0; k <= len; k++) begin
         @(posedge Clk); #1;
         if (k == 0) begin
            ADDR = a; Data_to_SRAM = wd; Mem_UB = ub; Mem_LB = lb;
         end else begin
            ADDR = AW'($urandom); Data_to_SRAM = 16'($urandom);
            Mem_UB = 1'($urandom); Mem_LB = 1'($urandom);
         end
         if (k < len) begin
            Mem_CE = ce_off;
            Mem_WE = !wr;
            Mem_OE = wr ? !both : 1'b0;
         end else begin
            Mem_CE = 1'($urandom); Mem_OE = 1'b1; Mem_WE = 1'b1;
         end
         @(negedge Clk);
         for (int d = 0; d < 2; d++) begin
            logic [15:0] ed;
            bit          er;
            w  = (d == 0) ? W_A : W_B;
            er = done[d] && (k >= w + 1) && (k <= len);
            ed = (!wr && done[d] && k >= w + 1) ? nd[d] : last[d];
            chk($sformatf("rdy_w%0d_%s_a%0d_k%0d", w, wr ? "wr" : "rd", a, k),
                {15'd0, (d == 0) ? rdy0 : rdy1}, {15'd0, er});
            chk($sformatf("data_w%0d_%s_a%0d_k%0d", w, wr ? "wr" : "rd", a, k),
                (d == 0) ? dout0 : dout1, ed);
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (done[d]) begin
            if (wr) begin
               if (!ub) mmem[d][a][15:8] = wd[15:8];
               if (!lb) mmem[d][a][7:0]  = wd[7:0];
               wrn[d]++;
            end else begin
               last[d] = nd[d];
               rdn[d]++;
            end
         end
      end
   endtask

   function automatic logic [AW-1:0] pool(input int i);
      return (i < 14) ? AW'(i) : AW'(1010 + i);
   endfunction

   initial begin
      Reset = 1'b0; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
      Mem_UB = 1'b1; Mem_LB = 1'b1; ADDR = '0; Data_to_SRAM = 16'h0;
      for (int d = 0; d < 2; d++) begin
         last[d] = 16'h0; rdn[d] = 0; wrn[d] = 0;
      end
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_rdy0", {15'd0, rdy0}, 16'h0);
      chk("reset_rdy1", {15'd0, rdy1}, 16'h0);
      chk("reset_data0", dout0, 16'h0);
      chk("reset_data1", dout1, 16'h0);
`ifdef SRAM_RESPONDER_STATS_EN
      chk("reset_rdc0", rdc0, 16'h0);
      chk("reset_wrc1", wrc1, 16'h0);
`endif
      Reset = 1'b1;

      for (int i = 0; i < 16; i++) xfer(1, 0, 0, 4, pool(i), 16'($urandom), 0, 0);

      // zero-wait write then two-cycle read
      xfer(1, 0, 0, 2, 10'd5, 16'h1234, 0, 0);
      xfer(0, 0, 0, 2, 10'd5, 16'h0, 0, 0);
      // byte lanes
      xfer(1, 0, 0, 4, 10'd7, 16'h1111, 0, 0);
      xfer(1, 0, 0, 4, 10'd7, 16'hABCD, 1, 0);
      xfer(0, 0, 0, 4, 10'd7, 16'h0, 0, 0);
      xfer(0, 0, 0, 4, 10'd7, 16'h0, 0, 1);
      // aborted vs completed read at three waits
      xfer(0, 0, 0, 2, 10'd7, 16'h0, 0, 0);
      xfer(0, 0, 0, 4, 10'd5, 16'h0, 0, 0);
      // long WE with changing data: one commit of the sampled value
      xfer(1, 0, 0, 10, 10'd9, 16'h5A5A, 0, 0);
      xfer(0, 0, 0, 5, 10'd9, 16'h0, 0, 0);
      // OE+WE both low is a write; CE high ignores strobes
      xfer(1, 1, 0, 4, 10'd3, 16'hC3C3, 0, 0);
      xfer(0, 0, 1, 5, 10'd3, 16'h0, 0, 0);
      xfer(0, 0, 0, 4, 10'd3, 16'h0, 0, 0);

      // reset while the slow responder is in RD_WAIT and the fast one holds data
      @(posedge Clk); #1;
      ADDR = 10'd5; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
      @(posedge Clk); #1;
      ADDR = 10'd7;
      @(negedge Clk);
      chk("prerst_rdy0", {15'd0, rdy0}, 16'h1);
      chk("prerst_data0", dout0, mmem[0][5]);
      #2 Reset = 1'b0;
      #1;
      chk("rst_rdy0", {15'd0, rdy0}, 16'h0);
      chk("rst_rdy1", {15'd0, rdy1}, 16'h0);
      chk("rst_data0", dout0, 16'h0);
      chk("rst_data1", dout1, 16'h0);
      @(posedge Clk); #1;
      Mem_OE = 1'b1; Mem_WE = 1'b0; ADDR = 10'd9; Data_to_SRAM = 16'hDEAD;
      @(posedge Clk); #1;
      Mem_WE = 1'b1; Mem_CE = 1'b1;
      @(negedge Clk);
      Reset = 1'b1;
      last[0] = 16'h0; last[1] = 16'h0;
      for (int d = 0; d < 2; d++) begin
         rdn[d] = 0; wrn[d] = 0;
      end
      xfer(0, 0, 0, 4, 10'd9, 16'h0, 0, 0);
      xfer(0, 0, 0, 4, 10'd5, 16'h0, 0, 0);

      for (int t = 0; t < 150; t++) begin
         bit wr;
         wr = 1'($urandom);
         xfer(wr, wr & 1'($urandom), ($urandom_range(7) == 0), int'($urandom_range(8, 1)),
              pool(int'($urandom_range(15))), 16'($urandom),
              ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      end

`ifdef SRAM_RESPONDER_STATS_EN
      chk("rd_count0", rdc0, 16'(rdn[0]));
      chk("rd_count1", rdc1, 16'(rdn[1]));
      chk("wr_count0", wrc0, 16'(wrn[0]));
      chk("wr_count1", wrc1, 16'(wrn[1]));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
